// File: rtl/output_packer.sv
`timescale 1ns/1ps
// output_packer
// Packs the 8-bit result stream into 32-bit words and drives the write
// port of write_memory at consecutive word addresses. Raises done (level)
// once TOTAL_BYTES bytes have been written; a partial last word is
// zero-padded.
//
// Ports:
//   clk, rst        clock (rising edge), async active-low reset
//   start           pulse; begins a run from IDLE or DONE
//   in_valid/in_data/in_ready  byte input handshake
//   write_en        one-cycle write strobe
//   addr            byte address of the word being written (mod 2^AW)
//   inp[0:3]        packed word, inp[0] = first byte received (bits 31:24)
//   busy            high in COLLECT or WRITE
//   done            high in DONE until the next start
module output_packer #(
  parameter  int WIDTH       = 64,
  parameter  int TOTAL_BYTES = 172,
  parameter  int BASE_ADDR   = 0,
  localparam int AW          = $clog2(WIDTH),
  localparam int CW          = $clog2(TOTAL_BYTES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                write_en,
  output logic [AW-1:0]       addr,
  output logic [0:3][7:0]     inp,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;

  state_e        state, state_nxt;
  logic [1:0]    slot;
  logic [CW-1:0] byte_cnt;
  logic          accept;
  logic          last_byte;
  logic          run_end;

  // All outputs decode from registered state only; in_valid never reaches
  // an output combinationally.
  assign in_ready = (state == COLLECT);
  assign write_en = (state == WRITE);
  assign busy     = (state == COLLECT) || (state == WRITE);
  assign done     = (state == DONE);

  assign accept    = (state == COLLECT) && in_valid;
  // byte_cnt is the count before the byte being accepted this cycle
  assign last_byte = (byte_cnt == CW'(TOTAL_BYTES - 1));
  assign run_end   = (byte_cnt == CW'(TOTAL_BYTES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = COLLECT;
      COLLECT:    if (accept && (slot == 2'd3 || last_byte)) state_nxt = WRITE;
      WRITE:      state_nxt = run_end ? DONE : COLLECT;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot     <= '0;
      byte_cnt <= '0;
      addr     <= '0;
      inp      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr     <= AW'(BASE_ADDR);
            byte_cnt <= '0;
            slot     <= '0;
            inp      <= '0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            inp[slot] <= in_data;
            slot      <= slot + 2'd1;
            byte_cnt  <= byte_cnt + CW'(1);
          end
        end
        WRITE: begin
          // Clearing inp here is what zero-pads a partial final word.
          if (!run_end) begin
            addr <= addr + AW'(4);
            slot <= '0;
            inp  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_packer.sv
`timescale 1ns/1ps
module tb_output_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // u0: main run, 172 bytes, addresses 0..168 fit in 8 bits
  logic s0, v0, r0, we0, b0, dn0;
  logic [7:0] d0, a0;
  logic [0:3][7:0] i0;
  output_packer #(.WIDTH(256), .TOTAL_BYTES(172), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst(rst), .start(s0), .in_valid(v0), .in_data(d0),
    .in_ready(r0), .write_en(we0), .addr(a0), .inp(i0), .busy(b0), .done(dn0));

  // u1: 6-byte run, table driven
  logic s1, v1, r1, we1, b1, dn1;
  logic [7:0] d1;
  logic [5:0] a1;
  logic [0:3][7:0] i1;
  output_packer #(.WIDTH(64), .TOTAL_BYTES(6), .BASE_ADDR(0)) u1 (
    .clk(clk), .rst(rst), .start(s1), .in_valid(v1), .in_data(d1),
    .in_ready(r1), .write_en(we1), .addr(a1), .inp(i1), .busy(b1), .done(dn1));

  // u2: address wrap-around
  logic s2, v2, r2, we2, b2, dn2;
  logic [7:0] d2;
  logic [3:0] a2;
  logic [0:3][7:0] i2;
  output_packer #(.WIDTH(16), .TOTAL_BYTES(8), .BASE_ADDR(12)) u2 (
    .clk(clk), .rst(rst), .start(s2), .in_valid(v2), .in_data(d2),
    .in_ready(r2), .write_en(we2), .addr(a2), .inp(i2), .busy(b2), .done(dn2));

  typedef logic [39:0] wr_t;   // {addr(8), word(32)}
  typedef wr_t wq_t[$];
  wq_t wq0, wq2, expq;
  logic [7:0] byts[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: split the byte list into 4-byte words, zero-pad the
  // tail, place word k at (base + 4k) mod 2^aw.
  task automatic build_exp(input int n, input int base, input int aw);
    expq.delete();
    for (int k = 0; k * 4 < n; k++) begin
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < n) w[31 - 8 * j -: 8] = byts[4 * k + j];
      expq.push_back({8'((base + 4 * k) % (1 << aw)), w});
    end
  endtask

  task automatic check_writes(input string nm, input wq_t got);
    chk({nm, "_count"}, 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), 64'(got[i]), 64'(expq[i]));
  endtask

  // Write monitor, sampled on the falling edge
  logic p_we = 1'b0, p_dn = 1'b0;
  always @(negedge clk) begin
    if (we0) begin
      wq0.push_back({a0, i0});
      chk("wr_ready_low", 64'(r0), 64'd0);
    end
    if (dn0 && !p_dn) chk("done_after_write", 64'(p_we), 64'd1);
    p_we = we0;
    p_dn = dn0;
    if (we2) wq2.push_back({4'b0, a2, i2});
  end

  // Feeds byts[] into u0 through the handshake. Stops at done (wait_done)
  // or once nacc bytes are accepted. rnd toggles in_valid and sprinkles
  // start pulses that must be ignored while busy.
  task automatic drive0(input bit rnd, input int nacc, input bit wait_done, output int ncyc);
    int idx;
    bit rdy, v;
    idx  = 0;
    ncyc = 0;
    while (ncyc < 4000) begin
      if (wait_done ? dn0 : (idx >= nacc)) break;
      rdy = r0;
      v   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx >= nacc) v = 1'b0;
      v0  = v;
      d0  = v ? byts[idx] : 8'($urandom);
      s0  = rnd && ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      ncyc++;
      if (rdy && v) idx++;
    end
    v0 = 1'b0;
    s0 = 1'b0;
    if (ncyc >= 4000) chk("drive0_timeout", 64'(ncyc), 64'd0);
  endtask

  typedef struct {
    logic        start, valid;
    logic [7:0]  data;
    logic        rdy, we, busy, done;
    logic [5:0]  addr;
    logic [31:0] word;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic r, logic w,
                              logic b, logic dn, logic [5:0] a, logic [31:0] wd);
    vec_t t;
    t.start = s; t.valid = v; t.data = d;
    t.rdy = r; t.we = w; t.busy = b; t.done = dn; t.addr = a; t.word = wd;
    return t;
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, sz, idx;
    bit rdy;
    s0 = 0; v0 = 0; d0 = 0;
    s1 = 0; v1 = 0; d1 = 0;
    s2 = 0; v2 = 0; d2 = 0;

    // outputs are the state after the edge that consumed the inputs
    tbl[0]  = mk(1, 0, 8'h00, 1, 0, 1, 0, 6'd0, 32'h00000000);
    tbl[1]  = mk(0, 1, 8'h11, 1, 0, 1, 0, 6'd0, 32'h11000000);
    tbl[2]  = mk(0, 1, 8'h22, 1, 0, 1, 0, 6'd0, 32'h11220000);
    tbl[3]  = mk(0, 1, 8'h33, 1, 0, 1, 0, 6'd0, 32'h11223300);
    tbl[4]  = mk(0, 1, 8'h44, 0, 1, 1, 0, 6'd0, 32'h11223344);
    tbl[5]  = mk(0, 1, 8'h99, 1, 0, 1, 0, 6'd4, 32'h00000000); // ignored in WRITE
    tbl[6]  = mk(0, 0, 8'h77, 1, 0, 1, 0, 6'd4, 32'h00000000); // no valid
    tbl[7]  = mk(0, 1, 8'h55, 1, 0, 1, 0, 6'd4, 32'h55000000);
    tbl[8]  = mk(0, 1, 8'h66, 0, 1, 1, 0, 6'd4, 32'h55660000); // partial word
    tbl[9]  = mk(0, 1, 8'hAA, 0, 0, 0, 1, 6'd4, 32'h55660000);
    tbl[10] = mk(0, 0, 8'h00, 0, 0, 0, 1, 6'd4, 32'h55660000);
    tbl[11] = mk(1, 0, 8'h00, 1, 0, 1, 0, 6'd0, 32'h00000000); // restart from DONE
    tbl[12] = mk(1, 1, 8'h01, 1, 0, 1, 0, 6'd0, 32'h01000000); // start ignored
    tbl[13] = mk(0, 1, 8'h02, 1, 0, 1, 0, 6'd0, 32'h01020000);

    // reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_u0", 64'({r0, we0, b0, dn0, a0, i0}), 64'd0);
    chk("reset_u1", 64'({r1, we1, b1, dn1, a1, i1}), 64'd0);
    rst = 1'b1;

    // table vectors on u1
    for (int i = 0; i < 14; i++) begin
      s1 = tbl[i].start; v1 = tbl[i].valid; d1 = tbl[i].data;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 64'({r1, we1, b1, dn1, a1, i1}),
          64'({tbl[i].rdy, tbl[i].we, tbl[i].busy, tbl[i].done, tbl[i].addr, tbl[i].word}));
    end
    s1 = 0; v1 = 0;

    // back-to-back 0x00..0xAB
    byts.delete();
    for (int i = 0; i < 172; i++) byts.push_back(8'(i));
    build_exp(172, 0, 8);
    wq0.delete();
    s0 = 1; @(posedge clk); #1; s0 = 0;
    drive0(0, 172, 1, n);
    chk("b2b_cycles", 64'(n), 64'd215);
    check_writes("b2b", wq0);
    if (wq0.size() == 43) begin
      chk("b2b_word0", 64'(wq0[0][31:0]), 64'h00010203);
      chk("b2b_word42", 64'(wq0[42][31:0]), 64'hA8A9AAAB);
      chk("b2b_addr42", 64'(wq0[42][39:32]), 64'd168);
    end

    // restart from DONE, random in_valid and stray start pulses
    wq0.delete();
    s0 = 1; @(posedge clk); #1; s0 = 0;
    chk("restart_done", 64'(dn0), 64'd0);
    chk("restart_addr", 64'(a0), 64'd0);
    chk("restart_busy", 64'(b0), 64'd1);
    drive0(1, 172, 1, n);
    check_writes("rand", wq0);

    // reset after 10 accepted bytes
    wq0.delete();
    s0 = 1; @(posedge clk); #1; s0 = 0;
    drive0(0, 10, 0, n);
    sz = wq0.size();
    chk("pre_rst_writes", 64'(sz), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", 64'({r0, we0, b0, dn0, a0, i0}), 64'd0);
    v0 = 1;
    repeat (3) @(posedge clk);
    #1; v0 = 0; rst = 1'b1;
    chk("rst_no_write", 64'(wq0.size()), 64'(sz));
    chk("rst_idle", 64'({r0, b0, dn0}), 64'd0);
    byts.delete();
    byts.push_back(8'hC0); byts.push_back(8'hC1);
    byts.push_back(8'hC2); byts.push_back(8'hC3);
    s0 = 1; @(posedge clk); #1; s0 = 0;
    drive0(0, 4, 0, n);
    @(negedge clk); #1;
    chk("rst_rerun_count", 64'(wq0.size()), 64'(sz + 1));
    if (wq0.size() > 0)
      chk("rst_rerun_word", 64'(wq0[wq0.size() - 1]), 64'({8'd0, 32'hC0C1C2C3}));

    // wrap-around: WIDTH=16, BASE_ADDR=12, 8 bytes -> @12 then @0
    byts.delete();
    for (int i = 0; i < 8; i++) byts.push_back(8'($urandom));
    build_exp(8, 12, 4);
    wq2.delete();
    s2 = 1; @(posedge clk); #1; s2 = 0;
    idx = 0; n = 0;
    while (!dn2 && n < 200) begin
      rdy = r2;
      v2  = (idx < 8);
      d2  = (idx < 8) ? byts[idx] : 8'h00;
      @(posedge clk); #1;
      n++;
      if (rdy && idx < 8) idx++;
    end
    v2 = 0;
    chk("wrap_timeout", 64'(n < 200), 64'd1);
    check_writes("wrap", wq2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
